// File: rtl/activation_load_sequencer.sv
// Phase controller for the activation memory: streams one tile of activations
// into memory, waits for the weight path, inserts the index-clear cycle, then
// holds cal high for the calculation window and pulses done.
module activation_load_sequencer #(
    parameter int unsigned SIZE       = 8,
    parameter int unsigned ADDR_WIDTH = $clog2(SIZE * SIZE),
    parameter int unsigned CAL_CYCLES = 3 * SIZE - 1,
    parameter int unsigned CNT_WIDTH  = $clog2(CAL_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  act_valid,
    input  logic [6:0]            act_data,
    output logic                  act_ready,
    input  logic                  weight_load_done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [6:0]            mem_data,
    output logic                  load_mem_done,
    output logic                  cal,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned TILE = SIZE * SIZE;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWaitW,
        StPrep,
        StCalc,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   act_cnt_q, act_cnt_d;
    logic [CNT_WIDTH-1:0]  cal_cnt_q, cal_cnt_d;
    logic                  w_flag_q, w_flag_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [6:0]            mem_data_q, mem_data_d;
    logic                  hs;

    // Outputs are pure decodes of the registered state, so no input reaches an output.
    assign act_ready     = (state_q == StLoad);
    assign load_mem_done = !((state_q == StLoad) || (state_q == StWaitW));
    assign cal           = (state_q == StCalc);
    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);
    assign mem_addr      = mem_addr_q;
    assign mem_data      = mem_data_q;

    // Abort wins over a handshake offered in the same cycle.
    assign hs = act_valid & act_ready & ~abort;

    // Next-state, counters, weight flag and write-port capture.
    always_comb begin
        state_d    = state_q;
        act_cnt_d  = act_cnt_q;
        cal_cnt_d  = cal_cnt_q;
        w_flag_d   = w_flag_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;

        // Weight completion is only remembered while the tile is loading or waiting.
        if (((state_q == StLoad) || (state_q == StWaitW)) && weight_load_done) begin
            w_flag_d = 1'b1;
        end

        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d   = StLoad;
                        act_cnt_d = '0;
                        cal_cnt_d = '0;
                        w_flag_d  = 1'b0;
                    end
                end
                StLoad: begin
                    if (hs) begin
                        mem_addr_d = act_cnt_q[ADDR_WIDTH-1:0];
                        mem_data_d = act_data;
                        act_cnt_d  = act_cnt_q + (ADDR_WIDTH + 1)'(1);
                        if (act_cnt_q == (ADDR_WIDTH + 1)'(TILE - 1)) begin
                            state_d = StWaitW;
                        end
                    end
                end
                StWaitW: begin
                    if (w_flag_q || weight_load_done) begin
                        state_d = StPrep;
                    end
                end
                // One cycle with writes disabled and cal low clears the compensation index.
                StPrep: begin
                    state_d = StCalc;
                end
                StCalc: begin
                    cal_cnt_d = cal_cnt_q + CNT_WIDTH'(1);
                    if (cal_cnt_q == CNT_WIDTH'(CAL_CYCLES - 1)) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            act_cnt_q  <= '0;
            cal_cnt_q  <= '0;
            w_flag_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            act_cnt_q  <= act_cnt_d;
            cal_cnt_q  <= cal_cnt_d;
            w_flag_q   <= w_flag_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

endmodule

// File: tb/tb_activation_load_sequencer.sv
// Randomised self-checking bench for activation_load_sequencer with a
// phase-level reference model and per-cycle output comparison.
module tb_activation_load_sequencer;

    localparam int TILE = 64;
    localparam int CALN = 23;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_WAIT = 2;
    localparam int PH_PREP = 3;
    localparam int PH_CALC = 4;
    localparam int PH_DONE = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       act_valid = 1'b0;
    logic [6:0] act_data = '0;
    logic       weight_load_done = 1'b0;
    logic       act_ready;
    logic [5:0] mem_addr;
    logic [6:0] mem_data;
    logic       load_mem_done;
    logic       cal;
    logic       busy;
    logic       done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Reference model state.
    int m_phase = PH_IDLE;
    int m_hs = 0;
    int m_cal = 0;
    bit m_wflag = 1'b0;
    int m_addr = 0;
    int m_data = 0;

    // Memory image built from what the DUT actually writes, plus data the bench sent.
    int shadow [TILE];
    int sent_data [TILE];
    int cal_run = 0;
    int last_cal_run = 0;

    activation_load_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .act_valid        (act_valid),
        .act_data         (act_data),
        .act_ready        (act_ready),
        .weight_load_done (weight_load_done),
        .mem_addr         (mem_addr),
        .mem_data         (mem_data),
        .load_mem_done    (load_mem_done),
        .cal              (cal),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: tile progress tracked as phase plus handshake/cal counts.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_phase = PH_IDLE;
                m_hs = 0;
                m_cal = 0;
                m_wflag = 1'b0;
                m_addr = 0;
                m_data = 0;
            end else begin
                if ((m_phase == PH_LOAD || m_phase == PH_WAIT) && weight_load_done) m_wflag = 1'b1;
                if (abort) begin
                    m_phase = PH_IDLE;
                end else begin
                    case (m_phase)
                        PH_IDLE: if (start) begin
                            m_phase = PH_LOAD;
                            m_hs = 0;
                            m_cal = 0;
                            m_wflag = 1'b0;
                        end
                        PH_LOAD: if (act_valid) begin
                            m_addr = m_hs;
                            m_data = int'(act_data);
                            m_hs++;
                            if (m_hs == TILE) m_phase = PH_WAIT;
                        end
                        PH_WAIT: if (m_wflag) m_phase = PH_PREP;
                        PH_PREP: m_phase = PH_CALC;
                        PH_CALC: begin
                            m_cal++;
                            if (m_cal == CALN) m_phase = PH_DONE;
                        end
                        default: m_phase = PH_IDLE;
                    endcase
                end
            end
        end
    end

    // Per-cycle compare of every output against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("act_ready", act_ready, m_phase == PH_LOAD);
                chk("load_mem_done", load_mem_done, !(m_phase == PH_LOAD || m_phase == PH_WAIT));
                chk("cal", cal, m_phase == PH_CALC);
                chk("busy", busy, m_phase != PH_IDLE);
                chk("done", done, m_phase == PH_DONE);
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_data", mem_data, m_data);
                if (!load_mem_done) shadow[mem_addr] = int'(mem_data);
                if (cal) begin
                    cal_run++;
                end else begin
                    if (cal_run > 0) last_cal_run = cal_run;
                    cal_run = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_shadow();
        for (int i = 0; i < TILE; i++) shadow[i] = -1;
    endtask

    // Offers activations at pct% density until max_n handshakes; one weight pulse at handshake wld_hs.
    task automatic feed(input int max_n, input int pct, input int wld_hs, input bit inc_data);
        int n = 0;
        int guard = 0;
        bit sent = 1'b0;
        bit hs_now;
        while (n < max_n && guard < 2000) begin
            act_valid = ($urandom_range(0, 99) < pct);
            act_data = inc_data ? 7'(n + 5) : 7'($urandom);
            weight_load_done = (!sent && n == wld_hs);
            if (weight_load_done) sent = 1'b1;
            hs_now = act_valid && act_ready;
            if (hs_now) sent_data[n] = int'(act_data);
            tick();
            guard++;
            if (hs_now) n++;
        end
        act_valid = 1'b0;
        weight_load_done = 1'b0;
        chk("feed_count", n, max_n);
    endtask

    task automatic do_start(output int ts);
        start = 1'b1;
        ts = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        int k = 0;
        while (!done && k < budget) begin
            tick();
            k++;
        end
        chk("done_seen", done, 1);
        dcyc = cyc;
    endtask

    task automatic wait_cal(input int budget);
        int k = 0;
        while (!cal && k < budget) begin
            tick();
            k++;
        end
        chk("cal_seen", cal, 1);
    endtask

    initial begin
        int ts;
        int dc;
        int p;
        int wh;

        // Initial reset.
        #1 rst = 1'b1;
        repeat (2) tick();
        chk("rst_lmd", load_mem_done, 1);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // 1: reset asserted mid-LOAD takes effect immediately.
        do_start(ts);
        feed(10, 100, -1, 1'b1);
        act_valid = 1'b1;
        #3 rst = 1'b1;
        #1;
        chk("t1_lmd", load_mem_done, 1);
        chk("t1_cal", cal, 0);
        chk("t1_ready", act_ready, 0);
        chk("t1_busy", busy, 0);
        chk("t1_done", done, 0);
        chk("t1_addr", mem_addr, 0);
        repeat (3) tick();
        rst = 1'b0;
        act_valid = 1'b0;
        tick();
        chk("t1_post_busy", busy, 0);

        // 2: full tile, continuous valid, weights at handshake 20.
        clear_shadow();
        do_start(ts);
        feed(TILE, 100, 19, 1'b1);
        wait_done(200, dc);
        chk("t2_latency", dc - ts, 90);
        tick();
        chk("t2_cal_len", last_cal_run, CALN);
        for (int a = 0; a < TILE; a++) chk("t2_mem", shadow[a], a + 5);

        // 3: random backpressure, random data.
        clear_shadow();
        do_start(ts);
        feed(TILE, 50, 30, 1'b0);
        wait_done(200, dc);
        tick();
        chk("t3_cal_len", last_cal_run, CALN);
        for (int a = 0; a < TILE; a++) chk("t3_mem", shadow[a], sent_data[a]);

        // 4: weights arrive 10 cycles after the last handshake.
        do_start(ts);
        feed(TILE, 100, -1, 1'b1);
        repeat (9) tick();
        chk("t4_wait_lmd", load_mem_done, 0);
        chk("t4_wait_busy", busy, 1);
        weight_load_done = 1'b1;
        p = cyc;
        tick();
        weight_load_done = 1'b0;
        chk("t4_prep_lmd", load_mem_done, 1);
        chk("t4_prep_cal", cal, 0);
        wait_done(200, dc);
        chk("t4_latency", dc - p, 25);
        tick();
        chk("t4_cal_len", last_cal_run, CALN);

        // 5: abort on the 5th cal cycle, then a fresh tile needs a new weight pulse.
        do_start(ts);
        feed(TILE, 100, 3, 1'b1);
        wait_cal(50);
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_cal", cal, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        repeat (30) tick();
        do_start(ts);
        feed(TILE, 100, -1, 1'b1);
        repeat (20) tick();
        chk("t5_wait_lmd", load_mem_done, 0);
        chk("t5_wait_busy", busy, 1);
        weight_load_done = 1'b1;
        tick();
        weight_load_done = 1'b0;
        wait_done(200, dc);
        tick();

        // 6: ignored inputs.
        do_start(ts);
        feed(TILE, 100, 10, 1'b1);
        wait_cal(50);
        start = 1'b1;
        act_valid = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        act_valid = 1'b0;
        wait_done(200, dc);
        chk("t6_latency", dc - ts, 90);
        tick();
        weight_load_done = 1'b1;
        repeat (2) tick();
        weight_load_done = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("t6_start_abort", busy, 0);
        do_start(ts);
        feed(TILE, 100, -1, 1'b1);
        repeat (15) tick();
        chk("t6_wait_lmd", load_mem_done, 0);
        chk("t6_wait_cal", cal, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();

        // Random tiles: random density, weights early or late.
        for (int r = 0; r < 4; r++) begin
            wh = $urandom_range(0, 90);
            do_start(ts);
            feed(TILE, $urandom_range(30, 100), wh, 1'b0);
            if (wh >= TILE) begin
                repeat ($urandom_range(1, 8)) tick();
                weight_load_done = 1'b1;
                tick();
                weight_load_done = 1'b0;
            end
            wait_done(200, dc);
            tick();
            chk("rnd_cal_len", last_cal_run, CALN);
            repeat ($urandom_range(0, 4)) tick();
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
